// File: rtl/stateful_app_pkg.sv
// Shared constants and helpers for the stateful_app drain FIFO family.
package stateful_app_pkg;

    localparam int DROP_CNT_W = 16;

    // Ceiling log2 used to size pointers from a depth.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/stateful_app_drain_mem.sv
// Storage array for the drain FIFO: one write port, one asynchronous read port, no reset.
module stateful_app_drain_mem
    import stateful_app_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/stateful_app_drain_fifo.sv
// First-word-fall-through drain FIFO that drops words when full instead of stalling upstream.
// Optional drop statistics output enabled by defining STATEFUL_APP_DRAIN_STATS_EN.
module stateful_app_drain_fifo
    import stateful_app_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      out_ready,
    output logic [clog2(DEPTH):0]     count,
    output logic                      almost_full,
    output logic                      overflow
`ifdef STATEFUL_APP_DRAIN_STATS_EN
    ,
    output logic [DROP_CNT_W-1:0]     drop_cnt
`endif
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THRESH);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             almost_full_r;
    logic             overflow_r;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;
    logic [CNT_W-1:0] count_next_s;

    stateful_app_drain_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (in_data),
        .raddr (rd_ptr_r),
        .rdata (out_data)
    );

    // Handshake decode and next occupancy; a pop at full frees a slot for the same-cycle push.
    always_comb begin
        pop_s        = (count_r != {CNT_W{1'b0}}) && out_ready;
        push_s       = in_valid && ((count_r != FULL_CNT) || pop_s);
        drop_s       = in_valid && (count_r == FULL_CNT) && !pop_s;
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointer, occupancy and flag state; almost_full follows the post-update count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            almost_full_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r       <= count_next_s;
            almost_full_r <= (count_next_s >= AFULL_CNT);
            overflow_r    <= overflow_r | drop_s;
        end
    end

`ifdef STATEFUL_APP_DRAIN_STATS_EN
    logic [DROP_CNT_W-1:0] drop_cnt_r;

    // Saturating count of discarded words.
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt_r <= {DROP_CNT_W{1'b0}};
        end else if (drop_s && (drop_cnt_r != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_r <= drop_cnt_r + DROP_CNT_W'(1);
        end
    end

    assign drop_cnt = drop_cnt_r;
`endif

    assign out_valid   = (count_r != {CNT_W{1'b0}});
    assign count       = count_r;
    assign almost_full = almost_full_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_stateful_app_drain_fifo.sv
// Directed, table-driven bench for stateful_app_drain_fifo at WIDTH=8, DEPTH=4, AFULL_THRESH=3.
// Honours STATEFUL_APP_DRAIN_STATS_EN to also check drop_cnt.
module tb_stateful_app_drain_fifo;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] count;
    logic       almost_full;
    logic       overflow;
`ifdef STATEFUL_APP_DRAIN_STATS_EN
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    stateful_app_drain_fifo #(
        .WIDTH        (8),
        .DEPTH        (4),
        .AFULL_THRESH (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .almost_full (almost_full),
        .overflow    (overflow)
`ifdef STATEFUL_APP_DRAIN_STATS_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] d;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic [2:0] ec;
        logic       ea;
        logic       eo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic iv, logic [7:0] d, logic rdy,
                                logic ev, logic [7:0] ed, logic [2:0] ec, logic ea, logic eo);
        vec_t v;
        v.rst = rst; v.iv = iv; v.d = d; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.ec = ec; v.ea = ea; v.eo = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs away from the edge, then sample #1 after the rising edge.
    task automatic step(input logic rst, input logic iv, input logic [7:0] d, input logic rdy);
        @(negedge clk);
        reset     = rst;
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic ev, input logic [7:0] ed,
                             input logic [2:0] ec, input logic ea, input logic eo);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ".count"}, 32'(count), 32'(ec));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(ea));
        chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
        if (ev) begin
            chk({tag, ".out_data"}, 32'(out_data), 32'(ed));
        end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

        // Three pushes with no consumer, then drain.
        vecs.push_back(mk(1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 3'd1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 3'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 3'd3, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 3'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 3'd1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
        // Fill, overflow drop, then push+pop at full.
        vecs.push_back(mk(1'b1, 1'b1, 8'h41, 1'b0, 1'b1, 8'h41, 3'd1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h42, 1'b0, 1'b1, 8'h41, 3'd2, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h43, 1'b0, 1'b1, 8'h41, 3'd3, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h44, 1'b0, 1'b1, 8'h41, 3'd4, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 8'h41, 3'd4, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 8'h42, 3'd4, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h43, 3'd3, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 3'd2, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h66, 3'd1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1));
        // Push into an empty FIFO while the consumer is ready: visible one cycle later.
        vecs.push_back(mk(1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 8'h77, 3'd1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1));

        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk_state("reset", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].rdy);
            chk_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ec,
                      vecs[i].ea, vecs[i].eo);
        end

`ifdef STATEFUL_APP_DRAIN_STATS_EN
        chk("drop_cnt", 32'(drop_cnt), 32'd1);
`endif

        // Ten words streamed through with a continuous pop, wrapping the pointers.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'(i); out_ready = 1'b1;
            if (i > 0) begin
                chk($sformatf("stream%0d.out_valid", i), 32'(out_valid), 32'd1);
                chk($sformatf("stream%0d.out_data", i), 32'(out_data), 32'(i - 1));
            end
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d.count", i), 32'(count), 32'd1);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk_state("stream_end", 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);

        // Mid-stream reset with a word offered in the reset cycle.
        step(1'b1, 1'b1, 8'ha1, 1'b0);
        step(1'b1, 1'b1, 8'ha2, 1'b0);
        chk_state("hold2", 1'b1, 8'ha1, 3'd2, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'hb3, 1'b0);
        chk_state("midreset", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
`ifdef STATEFUL_APP_DRAIN_STATS_EN
        chk("drop_cnt_reset", 32'(drop_cnt), 32'd0);
`endif
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk_state("post_reset_idle", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hc1, 1'b0);
        chk_state("post_reset_push", 1'b1, 8'hc1, 3'd1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
